// File: rtl/trap_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : trap_controller                                            |
// | Description : Machine-mode trap controller. Owns mstatus, mie, mip,      |
// |               mtvec, mepc, mcause, mtval and mscratch. Arbitrates        |
// |               exceptions and interrupts by fixed priority and sequences  |
// |               trap entry / mret with a stallable redirect to fetch.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module trap_controller #(
  parameter int unsigned         NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK = '0,
  parameter bit                  VEC_EN    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_ext_int,
  input  logic               i_tim_int,
  input  logic               i_sft_int,
  input  logic               i_exc_valid,
  input  logic [4:0]         i_exc_cause,
  input  logic [31:0]        i_exc_pc,
  input  logic [31:0]        i_exc_tval,
  input  logic [31:0]        i_int_pc,
  input  logic               i_mret,
  input  logic               i_csr_we,
  input  logic [1:0]         i_csr_op,
  input  logic [11:0]        i_csr_addr,
  input  logic [31:0]        i_csr_wdata,
  input  logic               i_stall,
  output logic [31:0]        o_csr_rdata,
  output logic               o_csr_valid,
  output logic               o_redirect,
  output logic [31:0]        o_redirect_pc,
  output logic               o_busy
);

  // CSR address map
  localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] c_ADDR_MIE      = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] c_ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] c_ADDR_MIP      = 12'h344;

  // CSR operation encodings
  localparam logic [1:0] c_OP_RW = 2'd0;
  localparam logic [1:0] c_OP_RS = 2'd1;
  localparam logic [1:0] c_OP_RC = 2'd2;

  // Platform interrupt lines occupy mip/mie bits 16 .. 16+NUM_IRQ-1
  localparam logic [31:0] c_PLAT_MASK  = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
  // Writable mie bits: MSIE(3), MTIE(7), MEIE(11) and the platform lines
  localparam logic [31:0] c_MIE_MASK   = c_PLAT_MASK | 32'h0000_0888;
  // mtvec keeps the mode LSB only when vectored mode is supported
  localparam logic [31:0] c_MTVEC_MASK = VEC_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
  // Instruction addresses are word aligned
  localparam logic [31:0] c_PC_MASK    = 32'hFFFF_FFFC;

  // Standard interrupt cause codes
  localparam logic [4:0] c_CODE_MSI = 5'd3;
  localparam logic [4:0] c_CODE_MTI = 5'd7;
  localparam logic [4:0] c_CODE_MEI = 5'd11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SAVE     = 2'd1,
    S_REDIRECT = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t             r_state;

  // Architectural CSR state
  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [31:0]        r_mie;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [31:0]        r_mtval;
  logic [31:0]        r_mscratch;

  // Edge-triggered platform interrupt tracking
  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_edge_pend;

  // Trap information captured when the trap is accepted in IDLE
  logic               r_t_int;
  logic [4:0]         r_t_code;
  logic [31:0]        r_t_pc;
  logic [31:0]        r_t_tval;

  // Registered redirect outputs
  logic               r_redirect;
  logic [31:0]        r_redirect_pc;

  logic [NUM_IRQ-1:0] w_plat_mip;
  logic [NUM_IRQ-1:0] w_edge_rise;
  logic [NUM_IRQ-1:0] w_edge_clr;
  logic [31:0]        w_mip;
  logic [31:0]        w_pend;
  logic               w_int_req;
  logic               w_trap;
  logic [4:0]         w_int_code;
  logic [31:0]        w_csr_rdata;
  logic               w_csr_hit;
  logic [31:0]        w_csr_new;
  logic               w_csr_wen;
  logic [31:0]        w_tvec_base;
  logic [31:0]        w_trap_target;

  // Platform pending view: level lines follow the input, edge lines use the latch
  assign w_plat_mip  = (i_irq & ~EDGE_MASK) | (r_edge_pend & EDGE_MASK);
  assign w_edge_rise = i_irq & ~r_irq_d & EDGE_MASK;

  // Assemble mip from the three standard level sources and the platform lines
  always_comb begin
    w_mip                  = '0;
    w_mip[3]               = i_sft_int;
    w_mip[7]               = i_tim_int;
    w_mip[11]              = i_ext_int;
    w_mip[16 +: NUM_IRQ]   = w_plat_mip;
  end

  assign w_pend    = w_mip & r_mie;
  assign w_int_req = r_mstatus_mie & (|w_pend);
  // A trap is only accepted in IDLE; exceptions arriving while busy belong to
  // instructions that are being flushed and are therefore ignored.
  assign w_trap    = (r_state == S_IDLE) & (i_exc_valid | w_int_req);

  // Fixed-priority interrupt selection: later assignments override earlier
  // ones, so MEI > MSI > MTI > line 0 > ... > line NUM_IRQ-1.
  always_comb begin
    w_int_code = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (w_pend[16 + k]) begin
        w_int_code = 5'(16 + k);
      end
    end
    if (w_pend[7])  w_int_code = c_CODE_MTI;
    if (w_pend[3])  w_int_code = c_CODE_MSI;
    if (w_pend[11]) w_int_code = c_CODE_MEI;
  end

  // CSR read mux; unimplemented addresses read as zero
  always_comb begin
    w_csr_rdata = '0;
    w_csr_hit   = 1'b1;
    case (i_csr_addr)
      c_ADDR_MSTATUS:  w_csr_rdata = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      c_ADDR_MIE:      w_csr_rdata = r_mie;
      c_ADDR_MTVEC:    w_csr_rdata = r_mtvec;
      c_ADDR_MSCRATCH: w_csr_rdata = r_mscratch;
      c_ADDR_MEPC:     w_csr_rdata = r_mepc;
      c_ADDR_MCAUSE:   w_csr_rdata = r_mcause;
      c_ADDR_MTVAL:    w_csr_rdata = r_mtval;
      c_ADDR_MIP:      w_csr_rdata = w_mip;
      default:         w_csr_hit   = 1'b0;
    endcase
  end

  assign o_csr_rdata = w_csr_rdata;
  assign o_csr_valid = w_csr_hit;

  // Read-modify-write result of the current CSR instruction
  always_comb begin
    case (i_csr_op)
      c_OP_RW: w_csr_new = i_csr_wdata;
      c_OP_RS: w_csr_new = w_csr_rdata | i_csr_wdata;
      c_OP_RC: w_csr_new = w_csr_rdata & ~i_csr_wdata;
      default: w_csr_new = w_csr_rdata;
    endcase
  end

  // A write lands only from an undisturbed IDLE cycle: a coincident trap
  // flushes the instruction, and an mret in the same cycle takes precedence.
  assign w_csr_wen = i_csr_we & w_csr_hit & (r_state == S_IDLE) & ~w_trap & ~i_mret;

  // Edge-pending clear sources: the trap that services the line, or a CSR
  // write whose result leaves the bit at zero.
  always_comb begin
    w_edge_clr = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_edge_clr[k] = ((r_state == S_SAVE) && r_t_int && (r_t_code == 5'(16 + k))) ||
                      (w_csr_wen && (i_csr_addr == c_ADDR_MIP) && !w_csr_new[16 + k]);
    end
  end

  // Trap vector: direct base, or base + 4*code for vectored interrupts
  assign w_tvec_base = {r_mtvec[31:2], 2'b00};
  always_comb begin
    w_trap_target = w_tvec_base;
    if (VEC_EN && r_mtvec[0] && r_t_int) begin
      w_trap_target = w_tvec_base + {25'b0, r_t_code, 2'b00};
    end
  end

  // Edge detection and sticky pending bits for edge-triggered lines; a new
  // rising edge wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_d     <= '0;
      r_edge_pend <= '0;
    end else begin
      r_irq_d     <= i_irq;
      r_edge_pend <= ((r_edge_pend & ~w_edge_clr) | w_edge_rise) & EDGE_MASK;
    end
  end

  // Trap/return sequencer together with every CSR it updates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mscratch     <= '0;
      r_t_int        <= 1'b0;
      r_t_code       <= '0;
      r_t_pc         <= '0;
      r_t_tval       <= '0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            // Capture everything now; the CSRs are committed together in SAVE
            r_state  <= S_SAVE;
            r_t_int  <= ~i_exc_valid;
            r_t_code <= i_exc_valid ? i_exc_cause : w_int_code;
            r_t_pc   <= i_exc_valid ? i_exc_pc    : i_int_pc;
            r_t_tval <= i_exc_valid ? i_exc_tval  : 32'h0;
          end else if (i_mret) begin
            r_state        <= S_RETURN;
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            r_redirect     <= 1'b1;
            r_redirect_pc  <= r_mepc;
          end else if (w_csr_wen) begin
            case (i_csr_addr)
              c_ADDR_MSTATUS: begin
                r_mstatus_mie  <= w_csr_new[3];
                r_mstatus_mpie <= w_csr_new[7];
              end
              c_ADDR_MIE:      r_mie      <= w_csr_new & c_MIE_MASK;
              c_ADDR_MTVEC:    r_mtvec    <= w_csr_new & c_MTVEC_MASK;
              c_ADDR_MSCRATCH: r_mscratch <= w_csr_new;
              c_ADDR_MEPC:     r_mepc     <= w_csr_new & c_PC_MASK;
              c_ADDR_MCAUSE:   r_mcause   <= w_csr_new;
              c_ADDR_MTVAL:    r_mtval    <= w_csr_new;
              default: ;
            endcase
          end
        end
        S_SAVE: begin
          r_mepc         <= r_t_pc & c_PC_MASK;
          r_mcause       <= {r_t_int, 26'b0, r_t_code};
          r_mtval        <= r_t_tval;
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
          r_redirect     <= 1'b1;
          r_redirect_pc  <= w_trap_target;
          r_state        <= S_REDIRECT;
        end
        S_REDIRECT, S_RETURN: begin
          // Hold the request steady until fetch accepts it
          if (!i_stall) begin
            r_redirect <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_trap_controller                                         |
// | Description : Self-checking bench for trap_controller with a behavioural |
// |               CSR/priority model, directed scenarios and random traffic. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_trap_controller;

  localparam int unsigned       NIRQ  = 4;
  localparam logic [NIRQ-1:0]   EMASK = 4'b0100;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MSCR = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344, A_NONE = 12'h7C0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic            ext = 1'b0, tim = 1'b0, sft = 1'b0;
  logic            exc_valid = 1'b0;
  logic [4:0]      exc_cause = '0;
  logic [31:0]     exc_pc = '0, exc_tval = '0, int_pc = '0;
  logic            mret = 1'b0, csr_we = 1'b0, stall = 1'b0;
  logic [1:0]      csr_op = '0;
  logic [11:0]     csr_addr = '0;
  logic [31:0]     csr_wdata = '0;
  logic [31:0]     csr_rdata, redirect_pc;
  logic            csr_valid, redirect, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic            m_st_mie, m_st_mpie;
  logic [31:0]     m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [NIRQ-1:0] m_edge;

  trap_controller #(.NUM_IRQ(NIRQ), .EDGE_MASK(EMASK), .VEC_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_ext_int(ext), .i_tim_int(tim),
    .i_sft_int(sft), .i_exc_valid(exc_valid), .i_exc_cause(exc_cause),
    .i_exc_pc(exc_pc), .i_exc_tval(exc_tval), .i_int_pc(int_pc), .i_mret(mret),
    .i_csr_we(csr_we), .i_csr_op(csr_op), .i_csr_addr(csr_addr),
    .i_csr_wdata(csr_wdata), .i_stall(stall), .o_csr_rdata(csr_rdata),
    .o_csr_valid(csr_valid), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st_mie = 0; m_st_mpie = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_edge = '0;
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] v = '0;
    v[3] = sft; v[7] = tim; v[11] = ext;
    for (int k = 0; k < NIRQ; k++) v[16 + k] = EMASK[k] ? m_edge[k] : irq[k];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      A_MSTATUS: return (m_st_mie ? 32'h8 : 32'h0) | (m_st_mpie ? 32'h80 : 32'h0);
      A_MIE:     return m_mie;
      A_MTVEC:   return m_mtvec;
      A_MSCR:    return m_mscratch;
      A_MEPC:    return m_mepc;
      A_MCAUSE:  return m_mcause;
      A_MTVAL:   return m_mtval;
      A_MIP:     return m_mip();
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      A_MSTATUS: return 32'h0000_0088;
      A_MIE:     return 32'h000F_0888;
      A_MTVEC:   return 32'hFFFF_FFFD;
      A_MEPC:    return 32'hFFFF_FFFC;
      A_MSCR, A_MCAUSE, A_MTVAL: return 32'hFFFF_FFFF;
      default:   return 32'h0;
    endcase
  endfunction

  // Trap vector from the model's mtvec
  function automatic logic [31:0] m_target(input bit is_int, input int code);
    logic [31:0] base = m_mtvec & 32'hFFFF_FFFC;
    if (is_int && m_mtvec[0]) return base + 32'(code) * 4;
    return base;
  endfunction

  // Highest-priority enabled pending interrupt code, or -1 when none
  function automatic int m_winner();
    int prio [7] = '{11, 3, 7, 16, 17, 18, 19};
    logic [31:0] p = m_mip() & m_mie;
    if (!m_st_mie) return -1;
    foreach (prio[i]) if (p[prio[i]]) return prio[i];
    return -1;
  endfunction

  task automatic chk_csr(input string tag, input logic [11:0] a);
    csr_we = 0; csr_addr = a; #1;
    check(tag, csr_rdata, m_read(a));
  endtask

  // CSR instruction issued in a quiet IDLE cycle
  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    logic [31:0] old_v, new_v, merged;
    old_v = m_read(a);
    case (op)
      2'd0: new_v = d;
      2'd1: new_v = old_v | d;
      default: new_v = old_v & ~d;
    endcase
    merged = (old_v & ~wmask(a)) | (new_v & wmask(a));
    csr_we = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_we = 0;
    case (a)
      A_MSTATUS: begin m_st_mie = merged[3]; m_st_mpie = merged[7]; end
      A_MIE:     m_mie = merged;
      A_MTVEC:   m_mtvec = merged;
      A_MSCR:    m_mscratch = merged;
      A_MEPC:    m_mepc = merged;
      A_MCAUSE:  m_mcause = merged;
      A_MTVAL:   m_mtval = merged;
      A_MIP:     for (int k = 0; k < NIRQ; k++) if (EMASK[k] && !new_v[16 + k]) m_edge[k] = 0;
      default: ;
    endcase
  endtask

  // Called in an IDLE cycle where a trap condition is present
  task automatic run_trap(input string tag, input logic [31:0] tgt, input logic [31:0] cause,
                          input logic [31:0] pc, input logic [31:0] tval);
    check({tag, "_idle"}, {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    exc_valid = 0; csr_we = 0; mret = 0;
    check({tag, "_save_busy"}, {31'b0, busy}, 32'h1);
    check({tag, "_save_noredir"}, {31'b0, redirect}, 32'h0);
    @(posedge clk); #1;
    check({tag, "_redir"}, {31'b0, redirect}, 32'h1);
    check({tag, "_target"}, redirect_pc, tgt);
    @(posedge clk); #1;
    check({tag, "_done"}, {30'b0, busy, redirect}, 32'h0);
    m_mepc = pc & 32'hFFFF_FFFC; m_mcause = cause; m_mtval = tval;
    m_st_mpie = m_st_mie; m_st_mie = 0;
    if (cause[31] && cause[4:0] >= 5'd16) m_edge[cause[1:0]] = 0;
    chk_csr({tag, "_mepc"}, A_MEPC);
    chk_csr({tag, "_mcause"}, A_MCAUSE);
    chk_csr({tag, "_mtval"}, A_MTVAL);
    chk_csr({tag, "_mstatus"}, A_MSTATUS);
  endtask

  task automatic do_mret(input string tag);
    check({tag, "_idle"}, {31'b0, busy}, 32'h0);
    mret = 1;
    @(posedge clk); #1;
    mret = 0;
    check({tag, "_redir"}, {31'b0, redirect}, 32'h1);
    check({tag, "_target"}, redirect_pc, m_mepc);
    m_st_mie = m_st_mpie; m_st_mpie = 1;
    @(posedge clk); #1;
    check({tag, "_done"}, {31'b0, busy}, 32'h0);
    chk_csr({tag, "_mstatus"}, A_MSTATUS);
  endtask

  task automatic clear_inputs();
    ext = 0; tim = 0; sft = 0; irq = '0; exc_valid = 0; csr_we = 0; mret = 0;
  endtask

  initial begin
    logic [11:0] addrs [9] = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE,
                               A_MTVAL, A_MIP, A_NONE};
    logic [11:0] a;
    int          w;
    bit          is_int;
    int          code;

    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Reset state
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_redir", {31'b0, redirect}, 32'h0);
    check("rst_redir_pc", redirect_pc, 32'h0);
    foreach (addrs[i]) chk_csr("rst_csr", addrs[i]);

    // Direct-mode timer interrupt
    csr_wr(A_MTVEC, 2'd0, 32'h100);
    csr_wr(A_MIE, 2'd0, 32'h80);
    csr_wr(A_MSTATUS, 2'd0, 32'h8);
    tim = 1; int_pc = 32'h40;
    run_trap("mti", 32'h100, 32'h8000_0007, 32'h40, 32'h0);
    check("mti_mstatus_abs", m_read(A_MSTATUS), 32'h80);
    tim = 0;

    // Vectored mode, one-cycle pulse on edge-triggered line 2
    csr_wr(A_MTVEC, 2'd0, 32'h101);
    csr_wr(A_MIE, 2'd0, 32'h0004_0000);
    csr_wr(A_MSTATUS, 2'd0, 32'h8);
    irq = 4'b0100;
    @(posedge clk); #1;
    irq = '0;
    m_edge[2] = 1;
    chk_csr("edge_mip_set", A_MIP);
    run_trap("edge", 32'h148, 32'h8000_0012, 32'h40, 32'h0);
    chk_csr("edge_mip_clr", A_MIP);

    // Exception beats an enabled MEI; MEI taken after mret restores MIE
    csr_wr(A_MTVEC, 2'd0, 32'h100);
    csr_wr(A_MIE, 2'd0, 32'h800);
    csr_wr(A_MSTATUS, 2'd0, 32'h8);
    ext = 1; exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h80; exc_tval = 32'hdead;
    run_trap("exc", 32'h100, 32'h2, 32'h80, 32'hdead);
    do_mret("exc_mret");
    run_trap("mei", 32'h100, 32'h8000_000b, 32'h40, 32'h0);
    ext = 0;

    // Redirect held under a 3-cycle stall
    exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h200; exc_tval = 32'h11;
    @(posedge clk); #1;
    exc_valid = 0; stall = 1;
    check("stall_save", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_redir", {31'b0, redirect}, 32'h1);
      check("stall_pc", redirect_pc, 32'h100);
      if (i < 2) begin @(posedge clk); #1; end
    end
    stall = 0;
    @(posedge clk); #1;
    check("stall_idle", {31'b0, busy}, 32'h0);
    m_mepc = 32'h200; m_mcause = 32'h5; m_mtval = 32'h11; m_st_mpie = m_st_mie; m_st_mie = 0;
    chk_csr("stall_mcause", A_MCAUSE);

    // CSR write coincident with an enabled MSI is flushed
    csr_wr(A_MSCR, 2'd0, 32'h30);
    csr_wr(A_MIE, 2'd0, 32'h8);
    csr_wr(A_MSTATUS, 2'd0, 32'h8);
    sft = 1; csr_we = 1; csr_op = 2'd1; csr_addr = A_MSCR; csr_wdata = 32'h5;
    run_trap("msi", 32'h100, 32'h8000_0003, 32'h40, 32'h0);
    chk_csr("msi_mscratch", A_MSCR);
    check("msi_mscratch_abs", m_read(A_MSCR), 32'h30);
    sft = 0;

    // Random CSR read/modify/write traffic
    for (int i = 0; i < 40; i++) begin
      csr_wr(addrs[$urandom_range(0, 8)], 2'($urandom_range(0, 2)), $urandom);
      a = addrs[$urandom_range(0, 8)];
      chk_csr("rnd_csr", a);
      check("rnd_valid", {31'b0, csr_valid}, {31'b0, (a != A_NONE)});
    end

    // Random trap scenarios against the priority model
    for (int i = 0; i < 24; i++) begin
      csr_wr(A_MIE, 2'd0, $urandom & 32'h000F_0888);
      csr_wr(A_MSTATUS, 2'd0, 32'h8);
      ext = 1'($urandom); tim = 1'($urandom); sft = 1'($urandom);
      irq = 4'($urandom) & 4'b1011;
      exc_valid = ($urandom_range(0, 2) == 0);
      exc_cause = 5'($urandom_range(0, 15));
      exc_pc = $urandom; exc_tval = $urandom; int_pc = $urandom;
      w = m_winner();
      if (exc_valid || w >= 0) begin
        is_int = !exc_valid;
        code   = exc_valid ? int'(exc_cause) : w;
        run_trap("rnd_trap", m_target(is_int, code), {is_int, 26'b0, 5'(code)},
                 exc_valid ? exc_pc : int_pc, exc_valid ? exc_tval : 32'h0);
        clear_inputs();
        do_mret("rnd_mret");
      end else begin
        @(posedge clk); #1;
        check("rnd_notrap", {31'b0, busy}, 32'h0);
        clear_inputs();
      end
    end

    // Asynchronous reset while in SAVE
    exc_valid = 1; exc_cause = 5'd4; exc_pc = 32'h300; exc_tval = 32'h7;
    @(posedge clk); #1;
    exc_valid = 0;
    check("arst_in_save", {31'b0, busy}, 32'h1);
    #2 rst_n = 0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_redir", {31'b0, redirect}, 32'h0);
    check("arst_redir_pc", redirect_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_reset();
    @(posedge clk); #1;
    check("arst_idle", {31'b0, busy}, 32'h0);
    foreach (addrs[i]) chk_csr("arst_csr", addrs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
